// File: rtl/sum_acc_pkg.sv
// Shared types and widths for the sum accumulator and its readout FSM.
package sum_acc_pkg;

    localparam int ACC_W     = 16;
    localparam int CNT_W     = 8;
    localparam int OUT_BYTES = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_HI  = 2'd1,
        SEND_LO  = 2'd2,
        SEND_CNT = 2'd3
    } sum_acc_state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned adder that either clamps at all-ones or wraps, and reports carry-out.
module sat_add #(
    parameter int W      = 8,
    parameter int SAT_EN = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        ovf = raw[W];
        sum = raw[W-1:0];
        if (SAT_EN != 0 && raw[W]) begin
            sum = '1;
        end
    end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates valid sums into a running total and count, and streams a snapshot
// of both out as three bytes over a valid/ready handshake.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int SAT_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sum_in,
    input  logic       sum_valid,
    input  logic       clear,
    input  logic       rd_req,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       sat
);

    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sum;
    logic             sat_q, sat_d;
    logic             acc_ovf, cnt_ovf;

    logic [ACC_W-1:0] acc_s_q, acc_s_d;
    logic [CNT_W-1:0] cnt_s_q, cnt_s_d;
    logic [7:0]       out_data_q, out_data_d;
    sum_acc_state_t   state_q, state_d;
    logic             xfer;

    sat_add #(.W(ACC_W), .SAT_EN(SAT_EN)) u_acc_add (
        .a   (acc_q),
        .b   ({{(ACC_W-8){1'b0}}, sum_in}),
        .sum (acc_sum),
        .ovf (acc_ovf)
    );

    sat_add #(.W(CNT_W), .SAT_EN(SAT_EN)) u_cnt_add (
        .a   (cnt_q),
        .b   (CNT_W'(1)),
        .sum (cnt_sum),
        .ovf (cnt_ovf)
    );

    // Clear beats an accepted sample in the same cycle.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (sum_valid) begin
            acc_d = acc_sum;
            cnt_d = cnt_sum;
            if (SAT_EN != 0 && (acc_ovf || cnt_ovf)) begin
                sat_d = 1'b1;
            end
        end
    end

    assign out_valid = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign xfer      = out_valid && out_ready;

    // The next byte is loaded into out_data on the transfer edge, so it never depends on out_ready combinationally.
    always_comb begin
        state_d    = state_q;
        acc_s_d    = acc_s_q;
        cnt_s_d    = cnt_s_q;
        out_data_d = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    acc_s_d    = acc_q;
                    cnt_s_d    = cnt_q;
                    out_data_d = acc_q[ACC_W-1:8];
                    state_d    = SEND_HI;
                end
            end
            SEND_HI: begin
                if (xfer) begin
                    out_data_d = acc_s_q[7:0];
                    state_d    = SEND_LO;
                end
            end
            SEND_LO: begin
                if (xfer) begin
                    out_data_d = cnt_s_q;
                    state_d    = SEND_CNT;
                end
            end
            SEND_CNT: begin
                if (xfer) begin
                    out_data_d = 8'h00;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            acc_s_q    <= '0;
            cnt_s_q    <= '0;
            out_data_q <= 8'h00;
            state_q    <= IDLE;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            acc_s_q    <= acc_s_d;
            cnt_s_q    <= cnt_s_d;
            out_data_q <= out_data_d;
            state_q    <= state_d;
        end
    end

    assign out_data = out_data_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Drives a saturating and a wrapping instance with identical stimulus and checks
// both against an arithmetic model of totals, counts and three-byte readouts.
module tb_sum_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sum_in;
    logic       sum_valid, clear, rd_req, out_ready;

    logic [7:0] out_data_s, out_data_w;
    logic       out_valid_s, out_valid_w, busy_s, busy_w, sat_s, sat_w;

    sum_accumulator #(.SAT_EN(1)) dut_s (
        .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid), .clear(clear),
        .rd_req(rd_req), .out_data(out_data_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .busy(busy_s), .sat(sat_s)
    );

    sum_accumulator #(.SAT_EN(0)) dut_w (
        .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid), .clear(clear),
        .rd_req(rd_req), .out_data(out_data_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .busy(busy_w), .sat(sat_w)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: index 1 = saturating instance, index 0 = wrapping instance.
    int acc_m [2];
    int cnt_m [2];
    int sat_m [2];
    int sh    [2][3];
    int rem;

    logic [7:0] got_s[$];
    logic [7:0] got_w[$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            acc_m[k] = 0;
            cnt_m[k] = 0;
            sat_m[k] = 0;
        end
        rem = 0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] s, input logic c,
                              input logic r, input logic rdy);
        if (rem == 0) begin
            if (r) begin
                for (int k = 0; k < 2; k++) begin
                    sh[k][0] = acc_m[k] / 256;
                    sh[k][1] = acc_m[k] % 256;
                    sh[k][2] = cnt_m[k];
                end
                rem = 3;
            end
        end else if (rdy) begin
            rem--;
        end
        if (c) begin
            model_reset_live();
        end else if (v) begin
            for (int k = 0; k < 2; k++) begin
                int a, n;
                a = acc_m[k] + int'(s);
                n = cnt_m[k] + 1;
                if (k == 1) begin
                    if (a > 65535) begin a = 65535; sat_m[k] = 1; end
                    if (n > 255)   begin n = 255;   sat_m[k] = 1; end
                end else begin
                    a = a % 65536;
                    n = n % 256;
                end
                acc_m[k] = a;
                cnt_m[k] = n;
            end
        end
    endtask

    task automatic model_reset_live();
        for (int k = 0; k < 2; k++) begin
            acc_m[k] = 0;
            cnt_m[k] = 0;
            sat_m[k] = 0;
        end
    endtask

    task automatic check_outputs();
        check("valid_s", int'(out_valid_s), int'(rem != 0));
        check("valid_w", int'(out_valid_w), int'(rem != 0));
        check("busy_s", int'(busy_s), int'(rem != 0));
        check("busy_w", int'(busy_w), int'(rem != 0));
        check("sat_s", int'(sat_s), sat_m[1]);
        check("sat_w", int'(sat_w), sat_m[0]);
        if (rem != 0) begin
            check("data_s", int'(out_data_s), sh[1][3-rem]);
            check("data_w", int'(out_data_w), sh[0][3-rem]);
        end
    endtask

    // One clock: drive inputs, record transfers, clock, update model, check.
    task automatic step(input logic v, input logic [7:0] s, input logic c,
                        input logic r, input logic rdy);
        sum_valid = v;
        sum_in    = s;
        clear     = c;
        rd_req    = r;
        out_ready = rdy;
        if (out_valid_s && rdy) got_s.push_back(out_data_s);
        if (out_valid_w && rdy) got_w.push_back(out_data_w);
        @(posedge clk);
        #1;
        model_edge(v, s, c, r, rdy);
        check_outputs();
    endtask

    task automatic read_all();
        got_s.delete();
        got_w.delete();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8 && rem != 0; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("rd_done", int'(busy_s), 0);
    endtask

    task automatic expect_bytes(input string tag, input int s0, input int s1, input int s2,
                                input int w0, input int w1, input int w2);
        check({tag, "_n_s"}, got_s.size(), 3);
        check({tag, "_n_w"}, got_w.size(), 3);
        if (got_s.size() == 3 && got_w.size() == 3) begin
            check({tag, "_s0"}, int'(got_s[0]), s0);
            check({tag, "_s1"}, int'(got_s[1]), s1);
            check({tag, "_s2"}, int'(got_s[2]), s2);
            check({tag, "_w0"}, int'(got_w[0]), w0);
            check({tag, "_w1"}, int'(got_w[1]), w1);
            check({tag, "_w2"}, int'(got_w[2]), w2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sum_in = 8'h00; sum_valid = 1'b0; clear = 1'b0; rd_req = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid_s), 0);
        check("rst_busy", int'(busy_s), 0);
        check("rst_data", int'(out_data_s), 0);
        check("rst_sat", int'(sat_s), 0);
        @(negedge clk);
        rst = 1'b0;

        // Four samples then a full-speed readout.
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        read_all();
        expect_bytes("basic", 8'h00, 8'hA0, 8'h04, 8'h00, 8'hA0, 8'h04);
        check("basic_sat", int'(sat_s), 0);

        // 257 x 0xFF: total 0xFFFF exactly, count clamps / wraps.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 257; i++) step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        check("ff_sat_s", int'(sat_s), 1);
        check("ff_sat_w", int'(sat_w), 0);
        read_all();
        expect_bytes("ff257", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01);

        // 0xFFF0 + 0x20: clamp to 0xFFFF or wrap to 0x0010.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("clr_sat", int'(sat_s), 0);
        for (int i = 0; i < 256; i++) step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
        read_all();
        expect_bytes("accbnd", 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h10, 8'h02);

        // Clear wins over a same-cycle sample.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        read_all();
        expect_bytes("clrprio", 0, 0, 0, 0, 0, 0);

        // Stalled readout: ready pattern 0,0,1,0,1,1.
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        got_s.delete();
        got_w.delete();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("stall_busy_last", int'(busy_s), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("stall_busy_done", int'(busy_s), 0);
        expect_bytes("stall", 8'h00, 8'h46, 8'h02, 8'h00, 8'h46, 8'h02);

        // Clear and a second request during SEND_LO leave the shadow alone.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        got_s.delete();
        got_w.delete();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("lo_busy", int'(busy_s), 0);
        expect_bytes("midlo", 8'h01, 8'h80, 8'h03, 8'h01, 8'h80, 8'h03);
        read_all();
        expect_bytes("midlo_after", 0, 0, 0, 0, 0, 0);

        // Asynchronous reset while in SEND_HI.
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("pre_rst_busy", int'(busy_s), 1);
        rst = 1'b1;
        #1;
        check("arst_valid_s", int'(out_valid_s), 0);
        check("arst_busy_s", int'(busy_s), 0);
        check("arst_valid_w", int'(out_valid_w), 0);
        check("arst_data", int'(out_data_s), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        read_all();
        expect_bytes("post_rst", 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'(($urandom % 4) != 0), 8'($urandom), 1'(($urandom % 50) == 0),
                 1'(($urandom % 6) == 0), 1'(($urandom % 3) != 0));
        end
        for (int i = 0; i < 8 && rem != 0; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        read_all();
        check("rand_n", got_s.size(), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
